// File: rtl/fifo_sync_1r1w.sv
// ---------------------------------------------------------------------------
// fifo_sync_1r1w
//   Single-clock FIFO, one write port (valid/ready) and one show-ahead read
//   port (valid/yumi). The head entry is always visible on data_o and the
//   entry behind it on next_data_o, so a consumer can look one entry ahead.
//   Status flags come only from the registered occupancy count, so there is
//   no combinational path from yumi_i to ready_o.
// ---------------------------------------------------------------------------
module fifo_sync_1r1w #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8    // power of two, >= 2
) (
    input  logic             clk_i,
    input  logic             reset_n_i,   // active-high despite the name
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic [WIDTH-1:0] next_data_o,
    input  logic             yumi_i
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] TWO_COUNT  = (AW+1)'(2);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_next;
    logic [AW:0]      count;

    logic             enq;
    logic             deq;

    // Flags from registered state only; a full FIFO refuses a write even
    // when the same cycle pops, which keeps yumi_i off the ready_o path.
    assign ready_o = (count != FULL_COUNT);
    assign valid_o = (count != '0);

    // Accepted transfers; illegal pops (empty) and writes (full) are masked.
    assign enq = valid_i & ready_o;
    assign deq = yumi_i & valid_o;

    // DEPTH is a power of two, so the pointer wraps by natural overflow.
    assign rd_ptr_next = rd_ptr + AW'(1);

    // Show-ahead outputs forced to zero when the slot holds no live entry,
    // so stale array contents never leak out.
    assign data_o      = valid_o              ? mem[rd_ptr]      : '0;
    assign next_data_o = (count >= TWO_COUNT) ? mem[rd_ptr_next] : '0;

    // Storage write on accepted enqueue.
    // NOTE: the array is deliberately left out of reset; the count masks any
    // unwritten slot, and an unreset array maps onto plain flops or RAM.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem[wr_ptr] <= data_i;
        end
    end

    // Pointer and occupancy bookkeeping; reset discards all entries at once.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge reset_n_i) begin
        if (reset_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr_next;
            end
            case ({enq, deq})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_sync_1r1w.sv
// ---------------------------------------------------------------------------
// tb_fifo_sync_1r1w
//   Directed scenarios for fifo_sync_1r1w. Inputs change 1 ns after a rising
//   edge and outputs are sampled at that same point, away from the edge.
// ---------------------------------------------------------------------------
module tb_fifo_sync_1r1w;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;

    logic             clk_i = 1'b0;
    logic             reset_n_i;
    logic [WIDTH-1:0] data_i;
    logic             valid_i;
    logic             ready_o;
    logic             valid_o;
    logic [WIDTH-1:0] data_o;
    logic [WIDTH-1:0] next_data_o;
    logic             yumi_i;

    int passed = 0;
    int total  = 0;

    fifo_sync_1r1w #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .data_i      (data_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .valid_o     (valid_o),
        .data_o      (data_o),
        .next_data_o (next_data_o),
        .yumi_i      (yumi_i)
    );

    always #5 clk_i = ~clk_i;

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [WIDTH-1:0] v);
        valid_i = 1'b1;
        data_i  = v;
        tick();
        valid_i = 1'b0;
        data_i  = '0;
    endtask

    task automatic test_reset();
        valid_i   = 1'(($urandom) & 1);
        yumi_i    = 1'(($urandom) & 1);
        data_i    = WIDTH'($urandom);
        reset_n_i = 1'b1;
        tick();
        tick();
        total++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1 || data_o !== 8'h00 || next_data_o !== 8'h00)
            $display("FAIL reset_held: valid=%b ready=%b data=%h next=%h expected 0 1 00 00",
                     valid_o, ready_o, data_o, next_data_o);
        else passed++;
        valid_i = 1'b0;
        yumi_i  = 1'b0;
        data_i  = '0;
        #2 reset_n_i = 1'b0;
        tick();
        total++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1 || data_o !== 8'h00 || next_data_o !== 8'h00)
            $display("FAIL reset_released: valid=%b ready=%b data=%h next=%h expected 0 1 00 00",
                     valid_o, ready_o, data_o, next_data_o);
        else passed++;
    endtask

    task automatic test_ordering();
        logic [WIDTH-1:0] vals [5];
        vals[0] = 8'h3A; vals[1] = 8'h07; vals[2] = 8'hC5; vals[3] = 8'h11; vals[4] = 8'hFE;
        for (int i = 0; i < 5; i++) begin
            push(vals[i]);
            tick();
        end
        total++;
        if (next_data_o !== 8'h07)
            $display("FAIL order_next: next_data_o=%h expected 07", next_data_o);
        else passed++;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (valid_o !== 1'b1 || data_o !== vals[i])
                $display("FAIL order_pop%0d: valid=%b data=%h expected 1 %h", i, valid_o, data_o, vals[i]);
            else passed++;
            yumi_i = 1'b1;
            tick();
            yumi_i = 1'b0;
        end
        total++;
        if (valid_o !== 1'b0 || data_o !== 8'h00 || ready_o !== 1'b1)
            $display("FAIL order_empty: valid=%b data=%h ready=%b expected 0 00 1", valid_o, data_o, ready_o);
        else passed++;
    endtask

    task automatic test_full();
        for (int i = 0; i < DEPTH; i++) begin
            total++;
            if (ready_o !== 1'b1)
                $display("FAIL full_ready_before%0d: ready=%b expected 1", i, ready_o);
            else passed++;
            push(WIDTH'(i));
        end
        total++;
        if (ready_o !== 1'b0 || data_o !== 8'h00 || next_data_o !== 8'h01)
            $display("FAIL full_flag: ready=%b data=%h next=%h expected 0 00 01", ready_o, data_o, next_data_o);
        else passed++;
        // dropped write while full
        push(8'hAA);
        total++;
        if (ready_o !== 1'b0 || data_o !== 8'h00)
            $display("FAIL full_drop: ready=%b data=%h expected 0 00", ready_o, data_o);
        else passed++;
        // write while full with a simultaneous pop: write still refused
        valid_i = 1'b1;
        data_i  = 8'hAA;
        yumi_i  = 1'b1;
        tick();
        valid_i = 1'b0;
        yumi_i  = 1'b0;
        data_i  = '0;
        total++;
        if (ready_o !== 1'b1 || data_o !== 8'h01)
            $display("FAIL full_pop_refuse: ready=%b data=%h expected 1 01", ready_o, data_o);
        else passed++;
        for (int i = 1; i < DEPTH; i++) begin
            total++;
            if (valid_o !== 1'b1 || data_o !== WIDTH'(i))
                $display("FAIL full_drain%0d: valid=%b data=%h expected 1 %h", i, valid_o, data_o, WIDTH'(i));
            else passed++;
            yumi_i = 1'b1;
            tick();
            yumi_i = 1'b0;
        end
        total++;
        if (valid_o !== 1'b0 || data_o !== 8'h00)
            $display("FAIL full_empty: valid=%b data=%h expected 0 00", valid_o, data_o);
        else passed++;
    endtask

    task automatic test_simultaneous();
        logic [WIDTH-1:0] exp [3];
        exp[0] = 8'h20; exp[1] = 8'h30; exp[2] = 8'h40;
        push(8'h10);
        push(8'h20);
        push(8'h30);
        valid_i = 1'b1;
        data_i  = 8'h40;
        yumi_i  = 1'b1;
        tick();
        valid_i = 1'b0;
        yumi_i  = 1'b0;
        data_i  = '0;
        total++;
        if (data_o !== 8'h20 || next_data_o !== 8'h30 || ready_o !== 1'b1)
            $display("FAIL simul_head: data=%h next=%h ready=%b expected 20 30 1", data_o, next_data_o, ready_o);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (valid_o !== 1'b1 || data_o !== exp[i])
                $display("FAIL simul_drain%0d: valid=%b data=%h expected 1 %h", i, valid_o, data_o, exp[i]);
            else passed++;
            yumi_i = 1'b1;
            tick();
            yumi_i = 1'b0;
        end
        total++;
        if (valid_o !== 1'b0)
            $display("FAIL simul_empty: valid=%b expected 0", valid_o);
        else passed++;
    endtask

    task automatic test_empty_pop();
        yumi_i = 1'b1;
        tick();
        tick();
        yumi_i = 1'b0;
        total++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1 || data_o !== 8'h00 || next_data_o !== 8'h00)
            $display("FAIL empty_pop: valid=%b ready=%b data=%h next=%h expected 0 1 00 00",
                     valid_o, ready_o, data_o, next_data_o);
        else passed++;
        push(8'h55);
        total++;
        if (valid_o !== 1'b1 || data_o !== 8'h55 || next_data_o !== 8'h00)
            $display("FAIL empty_pop_write: valid=%b data=%h next=%h expected 1 55 00",
                     valid_o, data_o, next_data_o);
        else passed++;
        yumi_i = 1'b1;
        tick();
        yumi_i = 1'b0;
        total++;
        if (valid_o !== 1'b0)
            $display("FAIL empty_pop_drain: valid=%b expected 0", valid_o);
        else passed++;
    endtask

    task automatic test_wrap();
        logic [WIDTH-1:0] q [$];
        logic             wr;
        logic             rd;
        logic [WIDTH-1:0] v;
        push(8'h5F);
        q.push_back(8'h5F);
        for (int i = 0; i < 20; i++) begin
            wr = (q.size() < 3) && (i % 3 != 2);
            rd = (q.size() + int'(wr)) >= 2;
            v  = WIDTH'(8'h60 + i);
            total++;
            if (valid_o !== 1'b1 || data_o !== q[0])
                $display("FAIL wrap_head%0d: valid=%b data=%h expected 1 %h", i, valid_o, data_o, q[0]);
            else passed++;
            if (q.size() >= 2) begin
                total++;
                if (next_data_o !== q[1])
                    $display("FAIL wrap_next%0d: next_data_o=%h expected %h", i, next_data_o, q[1]);
                else passed++;
            end
            valid_i = wr;
            data_i  = v;
            yumi_i  = rd;
            tick();
            valid_i = 1'b0;
            yumi_i  = 1'b0;
            data_i  = '0;
            if (rd) void'(q.pop_front());
            if (wr) q.push_back(v);
        end
        while (q.size() > 0) begin
            total++;
            if (valid_o !== 1'b1 || data_o !== q[0])
                $display("FAIL wrap_drain: valid=%b data=%h expected 1 %h", valid_o, data_o, q[0]);
            else passed++;
            yumi_i = 1'b1;
            tick();
            yumi_i = 1'b0;
            void'(q.pop_front());
        end
        total++;
        if (valid_o !== 1'b0)
            $display("FAIL wrap_empty: valid=%b expected 0", valid_o);
        else passed++;
    endtask

    task automatic test_async_reset();
        push(8'hA1);
        push(8'hB2);
        total++;
        if (valid_o !== 1'b1 || data_o !== 8'hA1 || next_data_o !== 8'hB2)
            $display("FAIL areset_pre: valid=%b data=%h next=%h expected 1 A1 B2", valid_o, data_o, next_data_o);
        else passed++;
        #2 reset_n_i = 1'b1;
        #1;
        total++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1 || data_o !== 8'h00 || next_data_o !== 8'h00)
            $display("FAIL areset_immediate: valid=%b ready=%b data=%h next=%h expected 0 1 00 00",
                     valid_o, ready_o, data_o, next_data_o);
        else passed++;
        #1 reset_n_i = 1'b0;
        tick();
        push(8'hC3);
        total++;
        if (valid_o !== 1'b1 || data_o !== 8'hC3 || next_data_o !== 8'h00)
            $display("FAIL areset_after: valid=%b data=%h next=%h expected 1 C3 00", valid_o, data_o, next_data_o);
        else passed++;
    endtask

    initial begin
        reset_n_i = 1'b0;
        valid_i   = 1'b0;
        yumi_i    = 1'b0;
        data_i    = '0;
        #1;
        test_reset();
        test_ordering();
        test_full();
        test_simultaneous();
        test_empty_pop();
        test_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fifo_sync_1r1w.md
Name: fifo_sync_1r1w

Overview:
- Synchronous single-clock FIFO with one write port and one read port.
- Write side uses a valid/ready handshake.
- Read side is show-ahead: the head entry is always visible on data_o, and the consumer pops it by asserting yumi_i.
- Also exposes the entry behind the head (next_data_o) for consumers that look ahead. General-purpose buffering block between pipeline stages.

Parameters:
- WIDTH, 8, data width in bits.
- DEPTH, 8, number of entries; must be a power of two and at least 2.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- reset_n_i  input  1  reset, asynchronous and active-high (port name kept per codebase convention; asserted = 1).
- data_i  input  WIDTH  write data, sampled on the rising edge when valid_i & ready_o.
- valid_i  input  1  producer has data on data_i.
- ready_o  output  1  FIFO can accept a write (not full).
- valid_o  output  1  FIFO holds at least one entry (not empty).
- data_o  output  WIDTH  oldest entry (head).
- next_data_o  output  WIDTH  second-oldest entry (head+1).
- yumi_i  input  1  consumer takes the head this cycle; legal only while valid_o=1.

Behaviour:
- Storage: DEPTH x WIDTH register array, write pointer, read pointer, occupancy count of width $clog2(DEPTH)+1. Pointers wrap modulo DEPTH.
- Reset (reset_n_i=1, asynchronous):
  - Pointers and count clear to 0.
  - valid_o=0, ready_o=1, data_o=0, next_data_o=0.
  - Array contents need not be cleared.
  - Reset mid-operation discards all entries immediately.
- Enqueue: on a rising edge with valid_i=1 and ready_o=1:
  - data_i is written at the write pointer.
  - The write pointer increments.
- Dequeue: on a rising edge with yumi_i=1 and valid_o=1:
  - The read pointer increments.
  - The popped value is the one on data_o before that edge.
- Count update:
  - +1 on enqueue only.
  - -1 on dequeue only.
  - Unchanged when both occur in the same cycle.
- ready_o = (count != DEPTH).
  - Depends on registered state only; no combinational path from yumi_i.
  - When full, a write is refused even if a pop occurs in the same cycle.
- valid_o = (count != 0). Registered-state-derived.
- data_o:
  - Combinationally = array[read pointer] when valid_o=1, else 0.
  - Zero latency from storage: an entry written on edge N appears on data_o / valid_o after edge N.
- next_data_o = array[read pointer+1 mod DEPTH] when count >= 2, else 0.
- Ignored inputs:
  - valid_i while full: write dropped, no state change.
  - yumi_i while empty: ignored, no state change, no underflow.
- Simultaneous enqueue and dequeue at 0 < count < DEPTH:
  - Both take effect.
  - With count=1, the new entry becomes head after the edge.
- Ordering is strict first-in-first-out; no data is reordered or duplicated.
- Outputs have no X after reset, given defined inputs.

Test Plan:
- Reset: pulse reset_n_i high with random inputs -> valid_o=0, ready_o=1, data_o=0, next_data_o=0; asserting reset asynchronously mid-operation produces the same values immediately.
- Ordering: enqueue 0x3A, 0x07, 0xC5, 0x11, 0xFE (one-cycle valid_i pulses, idle cycle between), then 5 yumi_i pulses -> data_o reads 3A, 07, C5, 11, FE in order; next_data_o = 07 while 3A is head; valid_o=0 after the last pop.
- Full: write DEPTH=8 entries 0x00..0x07 -> ready_o=0 after the 8th; a 9th write of 0xAA is dropped; drain yields 00..07, never AA.
- Simultaneous: with 3 entries (10, 20, 30), assert valid_i (0x40) and yumi_i in the same cycle -> count stays 3, head becomes 20, drain yields 20, 30, 40.
- Empty pop: yumi_i=1 while empty -> no change; a following write of 0x55 appears on data_o with valid_o=1 after one edge.
- Wrap-around: 20 interleaved write/read cycles, keeping occupancy between 1 and 3 -> every value emerges in order across pointer wraps.
